// File: rtl/ccip_mmio_csr_bridge.sv
// CCI-P MMIO front end: queues c0 MMIO requests, serves them one at a time on a CSR req/ack bus,
// and returns read data (or an all-ones timeout response) on c2. Includes the minimal CCI-P types it needs.

package ccip_if_pkg;
    typedef logic [15:0] t_ccip_mmioAddr;
    typedef logic [8:0]  t_ccip_tid;

    typedef struct packed {
        t_ccip_mmioAddr address;
        logic [1:0]     length;
        logic           rsvd;
        t_ccip_tid      tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        logic [27:0]  hdr;
        logic [511:0] data;
        logic         rspValid;
        logic         mmioRdValid;
        logic         mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;
endpackage

module ccip_mmio_csr_bridge
    import ccip_if_pkg::*;
#(
    parameter int REQ_DEPTH   = 8,
    parameter int RSP_TIMEOUT = 512
) (
    input  logic           clk,
    input  logic           rst,
    input  t_if_ccip_Rx    cp2af_sRxPort,
    output t_if_ccip_c2_Tx af2cp_sTxC2,
    output logic           csr_req_valid,
    input  logic           csr_req_ready,
    output logic           csr_req_write,
    output logic [15:0]    csr_req_addr,
    output logic [1:0]     csr_req_len,
    output logic [63:0]    csr_req_wdata,
    input  logic           csr_rsp_valid,
    input  logic [63:0]    csr_rsp_rdata,
    output logic           overflow_err,
    output logic           timeout_err,
    output logic           proto_err
);
    localparam int AW = $clog2(REQ_DEPTH);
    localparam int CW = $clog2(RSP_TIMEOUT);

    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic [1:0]  len;
        logic [8:0]  tid;
        logic [63:0] data;
    } reqEntry_t;

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t              state, nextState;
    t_ccip_c0_ReqMmioHdr mmioHdr;
    reqEntry_t           fifoMem [REQ_DEPTH];
    reqEntry_t           newEntry, head;
    logic [AW:0]         wrPtr, rdPtr;
    logic                wrValid, rdValid, reqOne, empty, full, doPush, doPop, reqValid;
    logic                loadRsp, loadTimeout;
    logic [CW-1:0]       timeoutCnt;
    logic [8:0]          latchedTid, rspTid;
    logic [1:0]          latchedLen, rspLen;
    t_if_ccip_c2_Tx      c2Reg;
    logic                unusedRx;

    assign mmioHdr  = t_ccip_c0_ReqMmioHdr'(cp2af_sRxPort.c0.hdr);
    assign wrValid  = cp2af_sRxPort.c0.mmioWrValid;
    assign rdValid  = cp2af_sRxPort.c0.mmioRdValid;
    assign reqOne   = wrValid ^ rdValid;
    assign newEntry = '{write: wrValid, addr: mmioHdr.address, len: mmioHdr.length,
                        tid: mmioHdr.tid, data: cp2af_sRxPort.c0.data[63:0]};
    assign unusedRx = ^{cp2af_sRxPort.c0TxAlmFull, cp2af_sRxPort.c1TxAlmFull,
                        cp2af_sRxPort.c0.rspValid, cp2af_sRxPort.c0.data[511:64], mmioHdr.rsvd};

    // FWFT FIFO: extra pointer bit distinguishes full from empty; a pop frees room for a same-cycle push
    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPush = reqOne && (!full || doPop);
    assign head   = fifoMem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem[wrPtr[AW-1:0]] <= newEntry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            state <= IDLE;
        end else begin
            if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
            if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
            state <= nextState;
        end
    end

    // A response arriving in the read handshake cycle is taken immediately, skipping RD_WAIT
    always_comb begin
        nextState   = state;
        reqValid    = 1'b0;
        doPop       = 1'b0;
        loadRsp     = 1'b0;
        loadTimeout = 1'b0;
        case (state)
            IDLE: begin
                reqValid = !empty;
                if (reqValid && csr_req_ready) begin
                    doPop = 1'b1;
                    if (!head.write) begin
                        if (csr_rsp_valid) loadRsp = 1'b1;
                        else               nextState = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (csr_rsp_valid) begin
                    loadRsp   = 1'b1;
                    nextState = IDLE;
                end else if (timeoutCnt == CW'(RSP_TIMEOUT - 1)) begin
                    loadTimeout = 1'b1;
                    nextState   = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign rspTid = (state == IDLE) ? head.tid : latchedTid;
    assign rspLen = (state == IDLE) ? head.len : latchedLen;

    always_ff @(posedge clk) begin
        if (rst) begin
            c2Reg        <= '0;
            latchedTid   <= '0;
            latchedLen   <= '0;
            timeoutCnt   <= '0;
            overflow_err <= 1'b0;
            timeout_err  <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            c2Reg.mmioRdValid <= loadRsp | loadTimeout;
            if (loadRsp || loadTimeout) begin
                c2Reg.hdr.tid <= rspTid;
                if (loadTimeout)        c2Reg.data <= '1;
                else if (rspLen == 2'd0) c2Reg.data <= {32'h0, csr_rsp_rdata[31:0]};
                else                    c2Reg.data <= csr_rsp_rdata;
            end
            if (doPop && !head.write) begin
                latchedTid <= head.tid;
                latchedLen <= head.len;
                timeoutCnt <= '0;
            end else if (state == RD_WAIT && timeoutCnt != '1) begin
                timeoutCnt <= timeoutCnt + CW'(1);
            end
            if (reqOne && full && !doPop) overflow_err <= 1'b1;
            if (loadTimeout)              timeout_err  <= 1'b1;
            if (wrValid && rdValid)       proto_err    <= 1'b1;
        end
    end

    assign af2cp_sTxC2   = c2Reg;
    assign csr_req_valid = reqValid;
    assign csr_req_write = reqValid & head.write;
    assign csr_req_addr  = reqValid ? head.addr : '0;
    assign csr_req_len   = reqValid ? head.len  : '0;
    assign csr_req_wdata = reqValid ? head.data : '0;

endmodule

// File: tb/tb_ccip_mmio_csr_bridge.sv
// Directed self-checking bench for ccip_mmio_csr_bridge; inputs driven and outputs sampled on negedge.

module tb_ccip_mmio_csr_bridge;
    import ccip_if_pkg::*;

    localparam int REQ_DEPTH   = 8;
    localparam int RSP_TIMEOUT = 512;

    logic           clk = 1'b0;
    logic           rst;
    t_if_ccip_Rx    rxPort;
    t_if_ccip_c2_Tx txC2;
    logic           csrReqValid, csrReqReady, csrReqWrite;
    logic [15:0]    csrReqAddr;
    logic [1:0]     csrReqLen;
    logic [63:0]    csrReqWdata;
    logic           csrRspValid;
    logic [63:0]    csrRspRdata;
    logic           overflowErr, timeoutErr, protoErr;

    int checkCount = 0;
    int passCount  = 0;
    int c2Count    = 0;

    ccip_mmio_csr_bridge #(.REQ_DEPTH(REQ_DEPTH), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cp2af_sRxPort(rxPort), .af2cp_sTxC2(txC2),
        .csr_req_valid(csrReqValid), .csr_req_ready(csrReqReady), .csr_req_write(csrReqWrite),
        .csr_req_addr(csrReqAddr), .csr_req_len(csrReqLen), .csr_req_wdata(csrReqWdata),
        .csr_rsp_valid(csrRspValid), .csr_rsp_rdata(csrRspRdata),
        .overflow_err(overflowErr), .timeout_err(timeoutErr), .proto_err(protoErr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (txC2.mmioRdValid === 1'b1) c2Count++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1);
    end

    task automatic driveReq(input logic wr, input logic rd, input logic [15:0] addr,
                            input logic [1:0] len, input logic [8:0] tid, input logic [63:0] data);
        t_ccip_c0_ReqMmioHdr h;
        h = '0;
        h.address = addr;
        h.length  = len;
        h.tid     = tid;
        rxPort = '0;
        rxPort.c0.hdr = h;
        rxPort.c0.data[63:0] = data;
        rxPort.c0.mmioWrValid = wr;
        rxPort.c0.mmioRdValid = rd;
    endtask

    task automatic test_reset;
        rst = 1'b1; rxPort = '0; csrReqReady = 1'b0; csrRspValid = 1'b0; csrRspRdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkCount++;
        if (csrReqValid !== 1'b0) $display("[TB] FAIL reset_req_valid: got %b expected 0", csrReqValid);
        else passCount++;
        checkCount++;
        if (txC2 !== '0) $display("[TB] FAIL reset_c2: got %h expected 0", txC2);
        else passCount++;
        checkCount++;
        if ({overflowErr, timeoutErr, protoErr} !== 3'b000)
            $display("[TB] FAIL reset_errs: got %b expected 000", {overflowErr, timeoutErr, protoErr});
        else passCount++;
    endtask

    task automatic test_write;
        int c2Before;
        @(negedge clk);
        csrReqReady = 1'b1;
        driveReq(1'b1, 1'b0, 16'h0040, 2'd0, 9'h0, 64'h2);
        c2Before = c2Count;
        @(negedge clk);
        rxPort = '0;
        checkCount++;
        if ({csrReqValid, csrReqWrite, csrReqAddr} !== {1'b1, 1'b1, 16'h0040})
            $display("[TB] FAIL write_req: got v%b w%b a%h expected v1 w1 a0040", csrReqValid, csrReqWrite, csrReqAddr);
        else passCount++;
        checkCount++;
        if (csrReqWdata[31:0] !== 32'h2) $display("[TB] FAIL write_wdata: got %h expected 2", csrReqWdata[31:0]);
        else passCount++;
        repeat (4) @(negedge clk);
        checkCount++;
        if (csrReqValid !== 1'b0 || c2Count != c2Before)
            $display("[TB] FAIL write_after: got valid %b c2 pulses %0d expected valid 0 pulses 0", csrReqValid, c2Count - c2Before);
        else passCount++;
    endtask

    task automatic test_read(input string name, input logic [15:0] addr, input logic [1:0] len,
                             input logic [8:0] tid, input logic [63:0] rdata, input logic [63:0] expData);
        @(negedge clk);
        driveReq(1'b0, 1'b1, addr, len, tid, 64'h0);
        @(negedge clk);
        rxPort = '0;
        checkCount++;
        if ({csrReqValid, csrReqWrite, csrReqAddr, csrReqLen} !== {1'b1, 1'b0, addr, len})
            $display("[TB] FAIL %s_req: got v%b w%b a%h l%0d expected v1 w0 a%h l%0d", name,
                     csrReqValid, csrReqWrite, csrReqAddr, csrReqLen, addr, len);
        else passCount++;
        csrRspValid = 1'b1;
        csrRspRdata = rdata;
        @(negedge clk);
        csrRspValid = 1'b0;
        checkCount++;
        if ({txC2.mmioRdValid, txC2.hdr.tid, txC2.data} !== {1'b1, tid, expData})
            $display("[TB] FAIL %s_c2: got v%b tid %h data %h expected v1 tid %h data %h", name,
                     txC2.mmioRdValid, txC2.hdr.tid, txC2.data, tid, expData);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if ({txC2.mmioRdValid, txC2.data} !== {1'b0, expData})
            $display("[TB] FAIL %s_pulse_end: got v%b data %h expected v0 data %h", name,
                     txC2.mmioRdValid, txC2.data, expData);
        else passCount++;
    endtask

    task automatic test_timeout;
        int early;
        int c2Before;
        @(negedge clk);
        driveReq(1'b0, 1'b1, 16'h0043, 2'd1, 9'h077, 64'h0);
        @(negedge clk);
        rxPort = '0;
        checkCount++;
        if (csrReqValid !== 1'b1) $display("[TB] FAIL timeout_req: got %b expected 1", csrReqValid);
        else passCount++;
        early = 0;
        for (int i = 0; i < RSP_TIMEOUT; i++) begin
            @(negedge clk);
            if (txC2.mmioRdValid !== 1'b0 || csrReqValid !== 1'b0) early++;
        end
        checkCount++;
        if (early != 0) $display("[TB] FAIL timeout_wait: got %0d early events expected 0", early);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if ({txC2.mmioRdValid, txC2.hdr.tid, txC2.data, timeoutErr} !== {1'b1, 9'h077, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1})
            $display("[TB] FAIL timeout_c2: got v%b tid %h data %h err %b expected v1 tid 077 data all-ones err 1",
                     txC2.mmioRdValid, txC2.hdr.tid, txC2.data, timeoutErr);
        else passCount++;
        @(negedge clk);
        c2Before = c2Count;
        csrRspValid = 1'b1;
        csrRspRdata = 64'h1234;
        @(negedge clk);
        csrRspValid = 1'b0;
        repeat (3) @(negedge clk);
        checkCount++;
        if (c2Count != c2Before) $display("[TB] FAIL late_rsp: got %0d pulses expected 0", c2Count - c2Before);
        else passCount++;
    endtask

    task automatic test_overflow;
        int got;
        @(negedge clk);
        csrReqReady = 1'b0;
        for (int i = 0; i <= REQ_DEPTH; i++) begin
            driveReq(1'b0, 1'b1, 16'h0100 + 16'(i), 2'd1, 9'(i), 64'h0);
            @(negedge clk);
        end
        rxPort = '0;
        checkCount++;
        if ({overflowErr, csrReqValid, csrReqAddr} !== {1'b1, 1'b1, 16'h0100})
            $display("[TB] FAIL overflow_state: got err %b v%b a%h expected err 1 v1 a0100", overflowErr, csrReqValid, csrReqAddr);
        else passCount++;
        got = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (txC2.mmioRdValid === 1'b1) begin
                checkCount++;
                if (got >= REQ_DEPTH || txC2.hdr.tid !== 9'(got) || txC2.data !== {48'h0, 16'h0100 + 16'(got)})
                    $display("[TB] FAIL order_rsp%0d: got tid %h data %h expected tid %h data %h", got,
                             txC2.hdr.tid, txC2.data, 9'(got), {48'h0, 16'h0100 + 16'(got)});
                else passCount++;
                got++;
            end
            csrReqReady = 1'b1;
            csrRspValid = csrReqValid && !csrReqWrite;
            csrRspRdata = {48'h0, csrReqAddr};
            @(negedge clk);
        end
        csrRspValid = 1'b0;
        checkCount++;
        if (got != REQ_DEPTH) $display("[TB] FAIL order_count: got %0d responses expected %0d", got, REQ_DEPTH);
        else passCount++;
    endtask

    task automatic test_proto_and_reset;
        int c2Before;
        @(negedge clk);
        driveReq(1'b1, 1'b1, 16'h0050, 2'd0, 9'h0, 64'h55);
        @(negedge clk);
        rxPort = '0;
        checkCount++;
        if ({protoErr, csrReqValid} !== 2'b10)
            $display("[TB] FAIL proto: got err %b valid %b expected err 1 valid 0", protoErr, csrReqValid);
        else passCount++;
        csrReqReady = 1'b1;
        csrRspValid = 1'b0;
        driveReq(1'b0, 1'b1, 16'h0060, 2'd1, 9'h0EE, 64'h0);
        @(negedge clk);
        rxPort = '0;
        repeat (3) @(negedge clk);
        checkCount++;
        if (csrReqValid !== 1'b0) $display("[TB] FAIL rdwait_valid: got %b expected 0", csrReqValid);
        else passCount++;
        c2Before = c2Count;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkCount++;
        if ({txC2, csrReqValid, csrReqWrite, csrReqAddr, csrReqLen, csrReqWdata, overflowErr, timeoutErr, protoErr} !== '0)
            $display("[TB] FAIL midreset_outputs: got c2 %h v%b errs %b%b%b expected all 0",
                     txC2, csrReqValid, overflowErr, timeoutErr, protoErr);
        else passCount++;
        repeat (RSP_TIMEOUT + 20) @(negedge clk);
        checkCount++;
        if (c2Count != c2Before) $display("[TB] FAIL midreset_c2: got %0d pulses expected 0", c2Count - c2Before);
        else passCount++;
    endtask

    task automatic test_full_with_pop;
        int seen;
        @(negedge clk);
        csrReqReady = 1'b0;
        for (int i = 0; i < REQ_DEPTH; i++) begin
            driveReq(1'b1, 1'b0, 16'h0200 + 16'(i), 2'd0, 9'h0, 64'(i));
            @(negedge clk);
        end
        driveReq(1'b1, 1'b0, 16'h0200 + 16'(REQ_DEPTH), 2'd0, 9'h0, 64'(REQ_DEPTH));
        csrReqReady = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (csrReqValid === 1'b1) begin
                checkCount++;
                if (csrReqAddr !== 16'h0200 + 16'(seen))
                    $display("[TB] FAIL fullpop_wr%0d: got addr %h expected %h", seen, csrReqAddr, 16'h0200 + 16'(seen));
                else passCount++;
                seen++;
            end
            @(negedge clk);
            rxPort = '0;
        end
        checkCount++;
        if (seen != REQ_DEPTH + 1 || overflowErr !== 1'b0)
            $display("[TB] FAIL fullpop_count: got %0d writes err %b expected %0d writes err 0", seen, overflowErr, REQ_DEPTH + 1);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read("read8", 16'h0041, 2'd1, 9'h1A5, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);
        test_read("read4", 16'h0042, 2'd0, 9'h033, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0000_0000_CCCC_DDDD);
        test_timeout();
        test_overflow();
        test_proto_and_reset();
        test_full_with_pop();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
